pipeline_interlock: RTL

Hazard interlock and pipeline sequencer for the 5-stage datapath (IF, ID, EXE, MEM, WB). It sits beside the IF/ID and ID/EXE pipeline registers. It keeps its own shadow of the in-flight destination registers and decides each cycle whether the ID-stage instruction issues or stalls. It drives the PC and IF/ID write enables and the ID/EXE bubble, and sequences halt/drain/resume. It also keeps stall and retire counters for debug.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/shadow_match.sv | 22 ++
 rtl/pipeline_interlock.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline interlock: sequencer states and the shadow
// pipeline entry tracking an in-flight destination register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic       v;
    logic       w;
    logic [4:0] dest;
  } shadow_t;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam shadow_t    SHADOW_EMPTY = '{v: 1'b0, w: 1'b0, dest: REG_ZERO};

endpackage

// File: rtl/shadow_match.sv
// Compares one ID-stage source register against the EXE and MEM shadow
// entries; WB is excluded because the register file writes before the ID read.
module shadow_match
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       use_src,
  input  shadow_t    exe,
  input  shadow_t    mem,
  output logic       hit
);

  logic exe_hit;
  logic mem_hit;

  always_comb begin
    exe_hit = exe.v & exe.w & (exe.dest == src);
    mem_hit = mem.v & mem.w & (mem.dest == src);
    hit     = use_src & (src != REG_ZERO) & (exe_hit | mem_hit);
  end

endmodule

// File: rtl/pipeline_interlock.sv
// Hazard interlock and halt/drain sequencer for the 5-stage datapath, with
// debug stall and retire counters.
module pipeline_interlock
  import pipe_pkg::*;
#(
  parameter int STALL_CNT_W  = 16,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    d_valid,
  input  logic [4:0]              d_rs,
  input  logic [4:0]              d_rt,
  input  logic                    d_use_rs,
  input  logic                    d_use_rt,
  input  logic                    d_wreg,
  input  logic [4:0]              d_dest,
  input  logic                    halt_req,
  input  logic                    resume,
  input  logic                    clr_cnt,
  output logic                    pc_we,
  output logic                    ifid_we,
  output logic                    idexe_bubble,
  output logic [1:0]              state,
  output logic                    busy,
  output logic [STALL_CNT_W-1:0]  stall_cnt,
  output logic [RETIRE_CNT_W-1:0] retire_cnt
);

  // state     | meaning
  // ST_RUN    | issue when hazard-free; halt_req moves to DRAIN
  // ST_DRAIN  | fetch frozen, no issue; waits for the shadow pipe to empty
  // ST_HALTED | frozen; resume with halt_req low returns to RUN
  // 2'd3      | illegal, recovers to RUN on the next edge

  localparam logic [STALL_CNT_W-1:0]  STALL_ONE  = STALL_CNT_W'(1);
  localparam logic [RETIRE_CNT_W-1:0] RETIRE_ONE = RETIRE_CNT_W'(1);

  state_e                  state_q,  state_d;
  shadow_t                 exe_q,    exe_d;
  shadow_t                 mem_q,    mem_d;
  logic                    wb_v_q,   wb_v_d;
  logic [STALL_CNT_W-1:0]  stall_q,  stall_d;
  logic [RETIRE_CNT_W-1:0] retire_q, retire_d;

  logic hit_rs;
  logic hit_rt;
  logic hazard;
  logic run;
  logic issue;

  shadow_match u_match_rs (
    .src     (d_rs),
    .use_src (d_use_rs),
    .exe     (exe_q),
    .mem     (mem_q),
    .hit     (hit_rs)
  );

  shadow_match u_match_rt (
    .src     (d_rt),
    .use_src (d_use_rt),
    .exe     (exe_q),
    .mem     (mem_q),
    .hit     (hit_rt)
  );

  // The halt request cycle is treated as a non-issue cycle so IF/ID keeps its instruction.
  always_comb begin
    hazard = d_valid & (hit_rs | hit_rt);
    run    = (state_q == ST_RUN);
    issue  = run & ~halt_req & d_valid & ~hazard;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_RUN;
      exe_q    <= SHADOW_EMPTY;
      mem_q    <= SHADOW_EMPTY;
      wb_v_q   <= 1'b0;
      stall_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      exe_q    <= exe_d;
      mem_q    <= mem_d;
      wb_v_q   <= wb_v_d;
      stall_q  <= stall_d;
      retire_q <= retire_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (halt_req)             state_d = ST_DRAIN;
      ST_DRAIN:  if (!busy)                state_d = ST_HALTED;
      ST_HALTED: if (resume && !halt_req)  state_d = ST_RUN;
      default:                             state_d = ST_RUN;
    endcase
  end

  always_comb begin
    exe_d  = issue ? '{v: 1'b1, w: d_wreg, dest: d_dest} : SHADOW_EMPTY;
    mem_d  = exe_q;
    wb_v_d = mem_q.v;

    stall_d  = stall_q;
    retire_d = retire_q;
    if (clr_cnt) begin
      stall_d  = '0;
      retire_d = '0;
    end else begin
      if (run && hazard && !(&stall_q)) stall_d = stall_q + STALL_ONE;
      if (wb_v_q)                       retire_d = retire_q + RETIRE_ONE;
    end
  end

  always_comb begin
    pc_we        = run & ~halt_req & ~hazard;
    ifid_we      = run & ~halt_req & ~hazard;
    idexe_bubble = ~issue;
    busy         = exe_q.v | mem_q.v | wb_v_q;
    state        = state_q;
    stall_cnt    = stall_q;
    retire_cnt   = retire_q;
  end

endmodule
